// File: rtl/spic_pkg.sv
// Shared types and constants for the spic SPI responder.
// Frame layout, slave FSM states and MISO status bit positions.
package spic_pkg;

    localparam int S_TTYPE_W  = 1;
    localparam int S_SIZE_W   = 3;
    localparam int S_ADDR_W   = 32;
    localparam int S_DATA_W   = 32;
    localparam int S_STATUS_W = 4;

    localparam int ST_RD_DONE = 3;
    localparam int ST_OVERRUN = 2;
    localparam int ST_WR_ACK  = 1;
    localparam int ST_BUSY    = 0;

    typedef struct packed {
        logic [S_TTYPE_W-1:0] t_type;
        logic [S_SIZE_W-1:0]  size;
        logic [S_ADDR_W-1:0]  addr;
        logic [S_DATA_W-1:0]  data;
    } spic_frame_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DISPATCH,
        WAIT_RSP
    } spic_slv_state_e;

endpackage

// File: rtl/spic_sync_edge.sv
// Multi-flop synchronizer with single-cycle rise/fall pulses on the synchronized level.
// STAGES must be at least 2.
module spic_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spic_spi_slave.sv
// Oversampled SPI mode-0 responder: one frame in becomes one bus request out;
// the previous transaction's status and read data shift back on MISO.
module spic_spi_slave
    import spic_pkg::*;
#(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int FRAME_W     = AWIDTH + DWIDTH + S_TTYPE_W + S_SIZE_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sclk,
    input  logic                cs_n,
    input  logic                mosi,
    output logic                miso,
    output logic                req_valid,
    input  logic                req_ready,
    output logic                req_write,
    output logic [S_SIZE_W-1:0] req_size,
    output logic [AWIDTH-1:0]   req_addr,
    output logic [DWIDTH-1:0]   req_wdata,
    input  logic                rsp_valid,
    input  logic [DWIDTH-1:0]   rsp_rdata,
    output logic                err_overrun,
    output logic                err_short
);

    localparam int               CNT_W    = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   mosi_s;

    spic_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk_i(clk), .rst_n_i(rst_n), .d_i(sclk), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spic_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk_i(clk), .rst_n_i(rst_n), .d_i(cs_n), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_sync_q <= '0;
        else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    spic_slv_state_e        state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [FRAME_W-1:0]     frame_q, miso_sr_q, miso_load;
    logic                   miso_q, cs_active_q;
    logic                   req_write_q;
    logic [S_SIZE_W-1:0]    req_size_q;
    logic [AWIDTH-1:0]      req_addr_q, last_addr_q;
    logic [DWIDTH-1:0]      req_wdata_q, last_rdata_q;
    logic                   rd_done_q, wr_ack_q, overrun_q, short_q;
    logic [S_STATUS_W-1:0]  status_snap;
    logic                   frame_full, pending;

    assign frame_full = (bit_cnt_q == CNT_FULL);
    assign pending    = (state_q == DISPATCH) || (state_q == WAIT_RSP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (cs_fall) state_d = SHIFT;
            SHIFT:    if (frame_full) state_d = DISPATCH;
                      else if (cs_rise) state_d = IDLE;
            DISPATCH: if (req_ready) state_d = req_write_q ? IDLE : WAIT_RSP;
            WAIT_RSP: if (rsp_valid) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        req_valid = (state_q == DISPATCH);
    end

    always_comb begin
        status_snap             = '0;
        status_snap[ST_RD_DONE] = rd_done_q;
        status_snap[ST_OVERRUN] = overrun_q;
        status_snap[ST_WR_ACK]  = wr_ack_q;
        status_snap[ST_BUSY]    = pending;
    end
    assign miso_load = {status_snap, last_addr_q, last_rdata_q};

    // MISO runs on every selected frame, including overrun frames the FSM ignores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_active_q <= 1'b0;
            miso_q      <= 1'b0;
            miso_sr_q   <= '0;
        end else begin
            if (cs_fall)      cs_active_q <= 1'b1;
            else if (cs_rise) cs_active_q <= 1'b0;
            if (cs_fall) begin
                miso_q    <= miso_load[FRAME_W-1];
                miso_sr_q <= {miso_load[FRAME_W-2:0], 1'b0};
            end else if (sclk_fall && cs_active_q) begin
                miso_q    <= miso_sr_q[FRAME_W-1];
                miso_sr_q <= {miso_sr_q[FRAME_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            req_write_q <= 1'b0;
            req_size_q  <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            last_addr_q <= '0;
        end else begin
            if (state_q == IDLE && cs_fall) begin
                bit_cnt_q <= '0;
            end else if (state_q == SHIFT && sclk_rise && !frame_full) begin
                frame_q   <= {frame_q[FRAME_W-2:0], mosi_s};
                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            if (state_q == SHIFT && frame_full) begin
                req_write_q <= frame_q[FRAME_W-1];
                req_size_q  <= frame_q[FRAME_W-2 -: S_SIZE_W];
                req_addr_q  <= frame_q[DWIDTH +: AWIDTH];
                req_wdata_q <= frame_q[DWIDTH-1:0];
                last_addr_q <= frame_q[DWIDTH +: AWIDTH];
            end
        end
    end

    // Flags are read-to-clear on cs_fall; a set in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ack_q     <= 1'b0;
            rd_done_q    <= 1'b0;
            overrun_q    <= 1'b0;
            short_q      <= 1'b0;
            last_rdata_q <= '0;
        end else begin
            if (state_q == DISPATCH && req_ready && req_write_q) wr_ack_q <= 1'b1;
            else if (cs_fall)                                   wr_ack_q <= 1'b0;
            if (state_q == WAIT_RSP && rsp_valid) begin
                rd_done_q    <= 1'b1;
                last_rdata_q <= rsp_rdata;
            end else if (cs_fall) begin
                rd_done_q <= 1'b0;
            end
            if (cs_fall) overrun_q <= pending;
            if (state_q == SHIFT && cs_rise && !frame_full) short_q <= 1'b1;
            else if (cs_fall)                                short_q <= 1'b0;
        end
    end

    assign miso        = miso_q;
    assign req_write   = req_write_q;
    assign req_size    = req_size_q;
    assign req_addr    = req_addr_q;
    assign req_wdata   = req_wdata_q;
    assign err_overrun = overrun_q;
    assign err_short   = short_q;

endmodule

// File: tb/tb_spic_spi_slave.sv
// Bench for spic_spi_slave: SPI frames driven bit by bit, checked against a
// transaction-level model of requests, status flags and the MISO reply.
module tb_spic_spi_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int FW = 68;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sclk = 1'b0;
    logic          cs_n = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic          req_valid;
    logic          req_ready = 1'b0;
    logic          req_write;
    logic [2:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid = 1'b0;
    logic [DW-1:0] rsp_rdata = '0;
    logic          err_overrun;
    logic          err_short;

    always #5 clk = ~clk;

    spic_spi_slave #(
        .AWIDTH(AW), .DWIDTH(DW), .FRAME_W(FW), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .err_overrun(err_overrun), .err_short(err_short)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: status the responder should report, per transaction.
    bit        m_rd_done, m_ovr, m_wr_ack, m_busy, m_short;
    logic [31:0] m_addr, m_rdata;

    task automatic model_reset();
        m_rd_done = 0; m_ovr = 0; m_wr_ack = 0; m_busy = 0; m_short = 0;
        m_addr = '0; m_rdata = '0;
    endtask

    function automatic logic [FW-1:0] mk_frame(bit w, logic [2:0] sz, logic [31:0] a, logic [31:0] d);
        return {w, sz, a, d};
    endfunction

    // Ready responder: -1 ties ready high, N holds it low for N cycles of valid.
    int ready_delay = -1;
    int vcnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (ready_delay < 0) begin
                req_ready = 1'b1;
            end else if (req_valid) begin
                req_ready = (vcnt >= ready_delay);
                vcnt++;
            end else begin
                req_ready = 1'b0;
                vcnt = 0;
            end
        end
    end

    typedef struct {
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        int          run;
        bit          stable;
    } hs_t;
    hs_t hs_q[$];

    initial begin
        logic [67:0] first;
        int          run;
        bit          stable;
        first = '0; run = 0; stable = 1;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                run = 0; stable = 1;
            end else if (req_valid) begin
                if (run == 0) first = {req_write, req_size, req_addr, req_wdata};
                else if (first !== {req_write, req_size, req_addr, req_wdata}) stable = 0;
                run++;
                if (req_ready) begin
                    hs_q.push_back('{req_write, req_size, req_addr, req_wdata, run, stable});
                    run = 0; stable = 1;
                end
            end
        end
    end

    task automatic spi_xfer(input logic [FW-1:0] tx, input int nbits, input int abort_at,
                            output logic [FW-1:0] rx);
        rx = '0;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = (i < FW) ? tx[FW-1-i] : 1'($urandom);
            if (i == abort_at) begin
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                chk("async_reset_req", {req_valid, req_write, req_size, req_addr, req_wdata}, '0);
                chk("async_reset_flags", {miso, err_overrun, err_short}, '0);
                cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
                repeat (4) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            repeat (4) @(negedge clk);
            if (i < FW) rx[FW-1-i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_rsp(input logic [31:0] data);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        rsp_rdata = data;
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        rsp_rdata = $urandom;
        m_rdata = data; m_rd_done = 1; m_busy = 0;
    endtask

    // A response pulse outside WAIT_RSP must leave the model untouched.
    task automatic spurious_rsp();
        rsp_rdata = $urandom;
        rsp_valid = 1'b1;
        @(negedge clk);
        rsp_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_txn(input logic [FW-1:0] tx, input int nbits, input int abort_at,
                          input bit hold_rsp, input logic [31:0] rdata);
        logic [FW-1:0] rx, exp_rx;
        bit            was_busy;
        int            sh, exp_run;
        hs_t           h;
        exp_rx   = {m_rd_done, m_ovr, m_wr_ack, m_busy, m_addr, m_rdata};
        was_busy = m_busy;
        m_rd_done = 0; m_wr_ack = 0; m_short = 0; m_ovr = was_busy;
        spi_xfer(tx, nbits, abort_at, rx);
        if (abort_at >= 0) begin
            model_reset();
            hs_q.delete();
            chk("post_reset_no_req", hs_q.size(), 0);
            return;
        end
        sh = (nbits >= FW) ? 0 : FW - nbits;
        chk("miso_frame", rx >> sh, exp_rx >> sh);
        if (!was_busy && nbits >= FW) begin
            for (int c = 0; c < 300 && hs_q.size() == 0; c++) @(negedge clk);
            if (hs_q.size() == 0) begin
                chk("req_timeout", 0, 1);
            end else begin
                h = hs_q.pop_front();
                exp_run = (ready_delay < 0) ? 1 : ready_delay + 1;
                chk("req_fields", {h.w, h.sz, h.a, h.d}, tx);
                chk("req_valid_cycles", h.run, exp_run);
                chk("req_stable", h.stable, 1);
                m_addr = tx[63:32];
                if (tx[67]) begin
                    m_wr_ack = 1;
                end else begin
                    m_busy = 1;
                    if (!hold_rsp) send_rsp(rdata);
                end
            end
            repeat (4) @(negedge clk);
            chk("single_req", hs_q.size(), 0);
        end else begin
            if (!was_busy) m_short = 1;
            repeat (20) @(negedge clk);
            chk("no_req", hs_q.size(), 0);
        end
        chk("err_short", err_short, m_short);
        chk("err_overrun", err_overrun, m_ovr);
    endtask

    function automatic logic [FW-1:0] rnd_frame(bit w);
        return mk_frame(w, 3'($urandom), $urandom, $urandom);
    endfunction

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_outputs", {miso, req_valid, req_write, req_size, req_addr, req_wdata,
                              err_overrun, err_short}, '0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_no_valid", req_valid, 0);

        ready_delay = -1;
        do_txn(mk_frame(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF), FW, -1, 0, '0);
        ready_delay = 5;
        do_txn(mk_frame(1'b0, 3'b010, 32'h0000_0020, $urandom), FW, -1, 0, 32'hCAFE_F00D);
        ready_delay = -1;
        do_txn(rnd_frame(1'b1), 40, -1, 0, '0);
        do_txn(rnd_frame(1'b1), FW, -1, 0, '0);

        ready_delay = 1;
        do_txn(rnd_frame(1'b0), FW, -1, 1, '0);
        do_txn(rnd_frame(1'b1), FW, -1, 0, '0);
        send_rsp($urandom);
        do_txn(rnd_frame(1'b1), FW, -1, 0, '0);

        do_txn(rnd_frame(1'b1), FW, 30, 0, '0);
        do_txn(rnd_frame(1'b0), FW, -1, 0, $urandom);
        ready_delay = 0;
        do_txn(rnd_frame(1'b1), 72, -1, 0, '0);
        spurious_rsp();
        do_txn(rnd_frame(1'b0), FW, -1, 0, $urandom);

        for (int k = 0; k < 25; k++) begin
            int nb;
            ready_delay = int'($urandom_range(0, 5)) - 1;
            case ($urandom_range(0, 7))
                0:       nb = $urandom_range(1, FW - 1);
                1:       nb = $urandom_range(FW + 1, FW + 6);
                default: nb = FW;
            endcase
            if ($urandom_range(0, 5) == 0) spurious_rsp();
            do_txn(rnd_frame(1'($urandom)), nb, -1, 0, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks expected completion", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
